// File: rtl/pipeline_latch_pkg.sv
// Shared types for the pipeline_latch two-entry skid buffer.
package pipeline_latch_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_latch_if.sv
// Ready/valid handshake bundle between upstream, pipeline_latch and downstream.
interface pipeline_latch_if #(
    parameter int unsigned WIDTH = 32
);
    logic                                 in_valid;
    logic [WIDTH-1:0]                     in_data;
    logic                                 in_ready;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [WIDTH-1:0]                     out_data;
    logic [pipeline_latch_pkg::OCC_W-1:0] occupancy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipeline_latch_ctrl.sv
// Occupancy FSM and handshake decode; emits load enables for the data registers.
module pipeline_latch_ctrl
    import pipeline_latch_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OCC_W-1:0] occupancy,
    output logic             load_main,
    output logic             load_skid,
    output logic             skid_to_main
);

    state_e state_q, state_d;
    logic   accept, pop;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs decode from state only, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        case (state_q)
            ONE:     occupancy = OCC_W'(1);
            FULL:    occupancy = OCC_W'(2);
            default: occupancy = OCC_W'(0);
        endcase
    end

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (!accept && pop) begin
                    state_d = EMPTY;
                end else if (accept && pop) begin
                    load_main = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    skid_to_main = 1'b1;
                    state_d      = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d      = EMPTY;
            load_main    = 1'b0;
            load_skid    = 1'b0;
            skid_to_main = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_latch.sv
// Two-entry skid buffer: main/skid data registers driven by pipeline_latch_ctrl.
// Define PIPELINE_LATCH_TRISTATE_EN to add out_enable and a tri-state out_data drive.
module pipeline_latch
    import pipeline_latch_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
`ifdef PIPELINE_LATCH_TRISTATE_EN
    input  logic out_enable,
`endif
    pipeline_latch_if.slave bus
);

    logic [WIDTH-1:0] main_q, skid_q;
    logic             load_main, load_skid, skid_to_main;

    pipeline_latch_ctrl u_ctrl (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (bus.in_valid),
        .out_ready    (bus.out_ready),
        .in_ready     (bus.in_ready),
        .out_valid    (bus.out_valid),
        .occupancy    (bus.occupancy),
        .load_main    (load_main),
        .load_skid    (load_skid),
        .skid_to_main (skid_to_main)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            main_q <= RESET_VALUE;
            skid_q <= RESET_VALUE;
        end else begin
            if (load_main) begin
                main_q <= bus.in_data;
            end else if (skid_to_main) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= bus.in_data;
            end
        end
    end

`ifdef PIPELINE_LATCH_TRISTATE_EN
    assign bus.out_data = out_enable ? main_q : {WIDTH{1'bz}};
`else
    assign bus.out_data = main_q;
`endif

endmodule

// File: doc/pipeline_latch.md
PIPELINE_LATCH -- requirements
Module: pipeline_latch

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits (legal range 1..64).
REQ-002 Parameter RESET_VALUE, default 0, WIDTH-bit value loaded into both data registers on reset.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising clock edge.
REQ-005 flush  input  1  synchronous discard of all held entries.
REQ-006 in_valid  input  1  upstream presents in_data.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 in_ready  output  1  latch can accept this cycle.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_ready  input  1  downstream consumes this cycle.
REQ-011 out_data  output  WIDTH  head-entry payload.
REQ-012 occupancy  output  2  number of held entries, 0..2.

Function
REQ-013 The block SHALL be a two-entry skid buffer built from a main register and a skid register; out_data SHALL always be driven from the main register.
REQ-014 Accept occurs when in_valid=1 and in_ready=1; pop occurs when out_valid=1 and out_ready=1.
REQ-015 FSM states SHALL be EMPTY (occupancy 0), ONE (occupancy 1) and FULL (occupancy 2).
REQ-016 EMPTY: accept loads main and moves to ONE; no accept stays in EMPTY.
REQ-017 ONE: accept without pop loads skid and moves to FULL; pop without accept moves to EMPTY; simultaneous accept and pop loads main and stays in ONE.
REQ-018 FULL: pop copies skid into main and moves to ONE; no accept is possible in FULL.
REQ-019 in_ready SHALL equal (state != FULL), decoded from state registers only, with no combinational path from out_ready.
REQ-020 out_valid SHALL equal (state != EMPTY).
REQ-021 Latency SHALL be 1 cycle: data accepted at edge N is visible on out_data with out_valid=1 after edge N when the latch was EMPTY.
REQ-022 Order SHALL be preserved: entries leave in acceptance order, with no loss and no duplication.
REQ-023 flush=1 SHALL force EMPTY at the next edge, ignore any accept or pop in that cycle, and leave the data registers unchanged.
REQ-024 With in_valid=1 in FULL, in_data SHALL be ignored and state SHALL be unchanged unless pop occurs.
REQ-025 out_ready=1 while EMPTY SHALL have no effect.

Reset
REQ-026 When reset=0 at a rising edge, the FSM SHALL go to EMPTY and main and skid SHALL load RESET_VALUE, overriding flush, accept and pop in that cycle.
REQ-027 After reset: in_ready=1, out_valid=0, occupancy=0, out_data=RESET_VALUE.
REQ-028 Reset asserted mid-transfer SHALL discard all held entries; there is no partial-state retention.

Configuration
REQ-029 The macro PIPELINE_LATCH_TRISTATE_EN SHALL control the bus-drive feature.
REQ-030 With the macro defined, an extra 1-bit input out_enable SHALL exist, and out_data SHALL be main when out_enable=1 and high-impedance on all bits when out_enable=0; handshake, FSM and occupancy SHALL be unaffected by out_enable.
REQ-031 With the macro undefined, out_enable SHALL be absent and out_data SHALL be always driven.

Structure
REQ-032 Shared package pipeline_latch_pkg SHALL hold the state enumeration typedef (EMPTY/ONE/FULL) and the occupancy width constant OCC_W=2.
REQ-033 FSM and handshake decode SHALL live in sub-module pipeline_latch_ctrl, which produces in_ready, out_valid, occupancy and the load enables for main, skid and skid-to-main; the top level holds the data registers and the optional tri-state drive.

Verification
REQ-034 Reset: hold reset=0 for 2 cycles with in_valid=1 and in_data=0xDEADBEEF -> in_ready=1, out_valid=0, occupancy=0, out_data=0x00000000.
REQ-035 Single transfer: accept 0x11111111 with out_ready=0 -> next cycle out_valid=1, out_data=0x11111111, occupancy=1.
REQ-036 Skid fill: accept 0xA, then 0xB with out_ready=0 -> occupancy=2 and in_ready=0; then out_ready=1 for 2 cycles -> outputs 0xA then 0xB, then occupancy=0.
REQ-037 Streaming: in_valid=1 and out_ready=1 continuously with data 1,2,3,...,100 -> out_data sequence 1..100, occupancy constant at 1, in_ready constant at 1.
REQ-038 Flush while FULL: with flush=1 and in_valid=1 (0xC) in the same cycle -> next cycle occupancy=0, out_valid=0, and 0xC is not accepted.
REQ-039 Tri-state (macro defined): main=0x5A5A5A5A with out_enable=0 -> out_data all Z and out_valid=1; with out_enable=1 -> out_data=0x5A5A5A5A.
